// File: rtl/lru_victim_md_pkg.sv
// Shared cache parameters for the level-2 LRU replacement stage.
// Provides the level-2 geometry macros (defaulted here when the shared
// defines have not already set them) and package-level localparams.
`ifndef ASSOC_LV2
`define ASSOC_LV2 4
`endif
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 2
`endif
`ifndef NUM_SETS_LV2
`define NUM_SETS_LV2 16
`endif
`ifndef INDEX_WID_LV2
`define INDEX_WID_LV2 4
`endif

package lru_victim_md_pkg;

  localparam int unsigned ASSOC     = `ASSOC_LV2;
  localparam int unsigned ASSOC_WID = `ASSOC_WID_LV2;
  localparam int unsigned NUM_SETS  = `NUM_SETS_LV2;
  localparam int unsigned INDEX_WID = `INDEX_WID_LV2;

endpackage

// File: rtl/lru_victim_md_if.sv
// Bus between cache controller / free-block detector and the LRU victim stage.
// master: controller side (drives update, request and detector result).
// slave : LRU stage (returns registered victim).
interface lru_victim_md_if
  import lru_victim_md_pkg::*;
#(
  parameter int unsigned P_ASSOC_WID = ASSOC_WID,
  parameter int unsigned P_INDEX_WID = INDEX_WID
);

  logic                   lru_upd;
  logic [P_INDEX_WID-1:0] lru_upd_index;
  logic [P_ASSOC_WID-1:0] lru_upd_blk;
  logic                   victim_req;
  logic [P_INDEX_WID-1:0] victim_index;
  logic                   blk_free;
  logic [P_ASSOC_WID-1:0] free_blk_num;
  logic                   victim_vld;
  logic [P_ASSOC_WID-1:0] victim_blk_num;

  modport master (
    output lru_upd, lru_upd_index, lru_upd_blk,
    output victim_req, victim_index, blk_free, free_blk_num,
    input  victim_vld, victim_blk_num
  );

  modport slave (
    input  lru_upd, lru_upd_index, lru_upd_blk,
    input  victim_req, victim_index, blk_free, free_blk_num,
    output victim_vld, victim_blk_num
  );

endinterface

// File: rtl/lru_age_upd_md.sv
// Combinational true-LRU age update for one set.
// Ports: ages_in  - packed ages of the set (way w at [w*ASSOC_WID +: ASSOC_WID])
//        blk      - way being accessed (becomes MRU, age 0)
//        ages_out - packed ages after the access
module lru_age_upd_md
  import lru_victim_md_pkg::*;
#(
  parameter int unsigned P_ASSOC     = ASSOC,
  parameter int unsigned P_ASSOC_WID = ASSOC_WID
) (
  input  logic [P_ASSOC*P_ASSOC_WID-1:0] ages_in,
  input  logic [P_ASSOC_WID-1:0]         blk,
  output logic [P_ASSOC*P_ASSOC_WID-1:0] ages_out
);

  logic [P_ASSOC_WID-1:0] old_age;

  // Age of the accessed way before the update.
  always_comb begin
    old_age = '0;
    for (int w = 0; w < int'(P_ASSOC); w++) begin
      if (P_ASSOC_WID'(w) == blk) old_age = ages_in[w*P_ASSOC_WID +: P_ASSOC_WID];
    end
  end

  // Younger-than-old ways age by one; older ways keep their age. No wrap is
  // possible because only ages strictly below old_age are incremented.
  always_comb begin
    ages_out = ages_in;
    for (int w = 0; w < int'(P_ASSOC); w++) begin
      if (P_ASSOC_WID'(w) == blk) begin
        ages_out[w*P_ASSOC_WID +: P_ASSOC_WID] = '0;
      end else if (ages_in[w*P_ASSOC_WID +: P_ASSOC_WID] < old_age) begin
        ages_out[w*P_ASSOC_WID +: P_ASSOC_WID] =
          ages_in[w*P_ASSOC_WID +: P_ASSOC_WID] + P_ASSOC_WID'(1);
      end
    end
  end

endmodule

// File: rtl/lru_victim_md.sv
// True-LRU replacement choice per set. Tracks per-way ages, updates them on
// completed accesses and returns the allocation way one cycle after a request:
// the detector's free way if one exists, otherwise the set's LRU way.
// Ports: clk, rst_n (async active-low), bus (slave side of lru_victim_md_if).
module lru_victim_md
  import lru_victim_md_pkg::*;
#(
  parameter int unsigned P_ASSOC     = ASSOC,
  parameter int unsigned P_ASSOC_WID = ASSOC_WID,
  parameter int unsigned P_NUM_SETS  = NUM_SETS,
  parameter int unsigned P_INDEX_WID = INDEX_WID
) (
  input  logic          clk,
  input  logic          rst_n,
  lru_victim_md_if.slave bus
);

  localparam int unsigned AGES_WID = P_ASSOC * P_ASSOC_WID;

  // Every index value must map to a tracked set.
  if (P_NUM_SETS != (1 << P_INDEX_WID)) begin : g_bad_cfg
    $error("lru_victim_md: P_NUM_SETS must equal 2**P_INDEX_WID");
  end

  logic [AGES_WID-1:0]    age_q [P_NUM_SETS];
  logic [AGES_WID-1:0]    upd_cur_c;
  logic [AGES_WID-1:0]    upd_new_c;
  logic [AGES_WID-1:0]    req_cur_c;
  logic [P_ASSOC_WID-1:0] lru_way_c;
  logic [P_ASSOC_WID-1:0] choice_c;
  logic                   vld_q;
  logic [P_ASSOC_WID-1:0] blk_q;

  // Reset ordering: way w has age w, so the highest way is LRU.
  function automatic logic [AGES_WID-1:0] reset_ages();
    logic [AGES_WID-1:0] r;
    r = '0;
    for (int w = 0; w < int'(P_ASSOC); w++) r[w*P_ASSOC_WID +: P_ASSOC_WID] = P_ASSOC_WID'(w);
    return r;
  endfunction

  // Way holding the maximum age; ages are a permutation so exactly one matches.
  function automatic logic [P_ASSOC_WID-1:0] find_lru(input logic [AGES_WID-1:0] ages);
    logic [P_ASSOC_WID-1:0] r;
    r = '0;
    for (int w = 0; w < int'(P_ASSOC); w++) begin
      if (ages[w*P_ASSOC_WID +: P_ASSOC_WID] == P_ASSOC_WID'(P_ASSOC - 1)) r = P_ASSOC_WID'(w);
    end
    return r;
  endfunction

  // Set lookups for the update and request paths.
  always_comb begin
    upd_cur_c = age_q[bus.lru_upd_index];
    req_cur_c = age_q[bus.victim_index];
  end

  lru_age_upd_md #(
    .P_ASSOC     (P_ASSOC),
    .P_ASSOC_WID (P_ASSOC_WID)
  ) u_age_upd (
    .ages_in  (upd_cur_c),
    .blk      (bus.lru_upd_blk),
    .ages_out (upd_new_c)
  );

  // Victim uses pre-update ages even when an update hits the same set.
  always_comb begin
    lru_way_c = find_lru(req_cur_c);
    choice_c  = bus.blk_free ? bus.free_blk_num : lru_way_c;
  end

  // Age state and registered victim result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(P_NUM_SETS); s++) age_q[s] <= reset_ages();
      vld_q <= 1'b0;
      blk_q <= '0;
    end else begin
      if (bus.lru_upd) age_q[bus.lru_upd_index] <= upd_new_c;
      vld_q <= bus.victim_req;
      if (bus.victim_req) blk_q <= choice_c;
    end
  end

  assign bus.victim_vld     = vld_q;
  assign bus.victim_blk_num = blk_q;

endmodule

// File: tb/tb_lru_victim_md.sv
// Self-checking bench for lru_victim_md: directed scenarios then a randomized
// run against a recency-list reference model.
module tb_lru_victim_md;
  import lru_victim_md_pkg::*;

  localparam int A  = int'(ASSOC);
  localparam int AW = int'(ASSOC_WID);
  localparam int NS = int'(NUM_SETS);

  logic clk;
  logic rst_n;
  lru_victim_md_if bus ();

  lru_victim_md dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: per set, ways listed from most to least recently used.
  int order [NS][A];
  int n_pass;
  int n_checks;
  logic [AW-1:0] last_blk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < A; p++) order[s][p] = p;
  endtask

  task automatic model_touch(input int s, input int b);
    int p;
    p = 0;
    for (int i = 0; i < A; i++) if (order[s][i] == b) p = i;
    for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
    order[s][0] = b;
  endtask

  function automatic int model_lru(input int s);
    return order[s][A-1];
  endfunction

  // Expected packed ages: a way's age is its position in the recency list.
  function automatic logic [31:0] model_packed(input int s);
    logic [31:0] r;
    r = '0;
    for (int p = 0; p < A; p++) r[order[s][p]*AW +: AW] = AW'(p);
    return r;
  endfunction

  function automatic logic [31:0] dut_packed(input int s);
    return 32'(dut.age_q[s]);
  endfunction

  function automatic logic dut_all_perm();
    logic [31:0] v;
    int mask;
    for (int s = 0; s < NS; s++) begin
      v = dut_packed(s);
      mask = 0;
      for (int w = 0; w < A; w++) mask = mask | (1 << int'(v[w*AW +: AW]));
      if (mask != (1 << A) - 1) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive inputs, predict, advance, update model, check outputs.
  task automatic cyc(input string tag, input int upd, input int ui, input int ub,
                     input int req, input int vi, input int free, input int fnum);
    logic [AW-1:0] exp_blk;
    bus.lru_upd       = upd[0];
    bus.lru_upd_index = INDEX_WID'(ui);
    bus.lru_upd_blk   = ASSOC_WID'(ub);
    bus.victim_req    = req[0];
    bus.victim_index  = INDEX_WID'(vi);
    bus.blk_free      = free[0];
    bus.free_blk_num  = ASSOC_WID'(fnum);
    exp_blk = last_blk;
    if (req != 0) exp_blk = (free != 0) ? AW'(fnum) : AW'(model_lru(vi));
    @(posedge clk);
    #1;
    if (upd != 0) model_touch(ui, ub);
    last_blk = exp_blk;
    check({tag, "_vld"}, 32'(bus.victim_vld), 32'(req != 0));
    check({tag, "_blk"}, 32'(bus.victim_blk_num), 32'(exp_blk));
  endtask

  task automatic idle(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int u, ui, ub, rq, vi, fr, fn;
    logic ok;
    n_pass = 0;
    n_checks = 0;
    last_blk = '0;
    rst_n = 1'b0;
    bus.lru_upd = 1'b0;
    bus.lru_upd_index = '0;
    bus.lru_upd_blk = '0;
    bus.victim_req = 1'b0;
    bus.victim_index = '0;
    bus.blk_free = 1'b0;
    bus.free_blk_num = '0;
    model_reset();
    #12;
    check("rst_vld", 32'(bus.victim_vld), 32'd0);
    check("rst_blk", 32'(bus.victim_blk_num), 32'd0);
    check("rst_ages3", dut_packed(3), model_packed(3));
    rst_n = 1'b1;
    #4;

    // Reset ordering: LRU is the highest way.
    cyc("first_req", 0, 0, 0, 1, 3, 0, 0);
    idle("idle0");

    // Set 5: touch 3,2,1,0 then 3.
    cyc("s5_u3", 1, 5, 3, 0, 0, 0, 0);
    cyc("s5_u2", 1, 5, 2, 0, 0, 0, 0);
    cyc("s5_u1", 1, 5, 1, 0, 0, 0, 0);
    cyc("s5_u0", 1, 5, 0, 0, 0, 0, 0);
    cyc("s5_req", 0, 0, 0, 1, 5, 0, 0);
    cyc("s5_u3b", 1, 5, 3, 0, 0, 0, 0);
    cyc("s5_req2", 0, 0, 0, 1, 5, 0, 0);
    check("s5_ages", dut_packed(5), model_packed(5));

    // Free way overrides LRU and does not disturb ages.
    cyc("free_req", 0, 0, 0, 1, 0, 1, 1);
    check("s0_ages", dut_packed(0), model_packed(0));

    // Same-set update and request: victim from pre-update ages.
    cyc("same_set", 1, 2, 3, 1, 2, 0, 0);
    cyc("same_next", 0, 0, 0, 1, 2, 0, 0);
    // Touching the MRU way changes nothing.
    cyc("mru_touch", 1, 2, 3, 0, 0, 0, 0);
    check("s2_ages", dut_packed(2), model_packed(2));
    // Different sets in the same cycle.
    cyc("diff_set", 1, 7, 3, 1, 8, 0, 0);
    cyc("diff_next", 0, 0, 0, 1, 7, 0, 0);

    // Randomized run with a permutation check every cycle.
    for (int i = 0; i < 1000; i++) begin
      u  = int'($urandom_range(0, 1));
      ui = int'($urandom_range(0, NS - 1));
      ub = int'($urandom_range(0, A - 1));
      rq = int'($urandom_range(0, 1));
      vi = ($urandom_range(0, 3) == 0) ? ui : int'($urandom_range(0, NS - 1));
      fr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      fn = int'($urandom_range(0, A - 1));
      cyc("rnd", u, ui, ub, rq, vi, fr, fn);
      ok = dut_all_perm();
      check("rnd_perm", 32'(ok), 32'd1);
      check("rnd_ages", dut_packed(ui), model_packed(ui));
    end
    for (int s = 0; s < NS; s++) check("rnd_final_ages", dut_packed(s), model_packed(s));

    // Request in flight, then async reset before the next edge.
    cyc("pre_rst", 1, 4, 2, 1, 4, 0, 0);
    bus.lru_upd = 1'b0;
    bus.victim_req = 1'b1;
    bus.victim_index = INDEX_WID'(4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    last_blk = '0;
    check("async_vld", 32'(bus.victim_vld), 32'd0);
    check("async_blk", 32'(bus.victim_blk_num), 32'd0);
    bus.victim_req = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_vld", 32'(bus.victim_vld), 32'd0);
    for (int s = 0; s < NS; s++) check("rst_ages", dut_packed(s), model_packed(s));
    rst_n = 1'b1;
    #2;
    cyc("post_rst_req", 0, 0, 0, 1, 4, 0, 0);
    idle("post_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
